// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: receives a framed, checksummed configuration byte stream,
// assembles it in a shadow register and commits it atomically to the
// fpga_top select buses. A failed or aborted load never touches the buses.
//
// Handshake: a byte moves only on a rising edge where in_valid & in_ready are
// both high. in_ready is a pure function of state (high in SYNC/LOAD/CHECK),
// so it never depends on in_valid. in_data is ignored on any other cycle.
module fpga_cfg_loader #(
   parameter int         BRB_W     = 900,
   parameter int         BSB_W     = 1728,
   parameter int         LB_W      = 80,
   parameter int         IO_W      = 30,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [BRB_W-1:0] brbselect,
   output logic [BSB_W-1:0] bsbselect,
   output logic [LB_W-1:0]  lbselect,
   output logic [IO_W-1:0]  leftioselect,
   output logic [IO_W-1:0]  rightioselect,
   output logic [IO_W-1:0]  topioselect,
   output logic [IO_W-1:0]  bottomioselect,
   output logic             cfg_busy,
   output logic             cfg_done,
   output logic             cfg_error,
   output logic [2:0]       o_dbg_state
);

   localparam int TOTAL_W = BRB_W + BSB_W + LB_W + 4*IO_W;
   localparam int NBYTES  = (TOTAL_W + 7) / 8;
   localparam int CNT_W   = $clog2(NBYTES);
   localparam int BSB_LO  = BRB_W;
   localparam int LB_LO   = BSB_LO + BSB_W;
   localparam int LIO_LO  = LB_LO + LB_W;
   localparam int RIO_LO  = LIO_LO + IO_W;
   localparam int TIO_LO  = RIO_LO + IO_W;
   localparam int BIO_LO  = TIO_LO + IO_W;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SYNC  = 3'd1,
      S_LOAD  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               w_ready;
   logic               w_xfer;
   logic               w_commit;
   logic               w_restart;
   logic [CNT_W-1:0]   r_byte_cnt;
   logic [7:0]         r_csum;
   logic               r_done;
   logic               r_error;
   logic [8*NBYTES-1:0] r_shadow;
   logic [BRB_W-1:0]   r_brb;
   logic [BSB_W-1:0]   r_bsb;
   logic [LB_W-1:0]    r_lb;
   logic [IO_W-1:0]    r_lio;
   logic [IO_W-1:0]    r_rio;
   logic [IO_W-1:0]    r_tio;
   logic [IO_W-1:0]    r_bio;
   logic               w_unused_pad;

   assign w_ready   = (r_state == S_SYNC) || (r_state == S_LOAD) || (r_state == S_CHECK);
   assign w_xfer    = in_valid & w_ready;
   assign w_commit  = (r_state == S_CHECK) && w_xfer && (in_data == r_csum);
   assign w_restart = ((r_state == S_DONE) || (r_state == S_ERR)) && cfg_start;

   // Pad bits past TOTAL_W only feed the checksum; they never reach a bus.
   assign w_unused_pad = ^r_shadow[8*NBYTES-1:TOTAL_W];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic; cfg_start is only honoured in IDLE/DONE/ERR
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (cfg_start) w_next = S_SYNC;
         S_SYNC:  if (w_xfer && (in_data == SYNC_BYTE)) w_next = S_LOAD;
         S_LOAD:  if (w_xfer && (r_byte_cnt == CNT_W'(NBYTES-1))) w_next = S_CHECK;
         S_CHECK: if (w_xfer) w_next = (in_data == r_csum) ? S_DONE : S_ERR;
         S_DONE:  if (cfg_start) w_next = S_SYNC;
         S_ERR:   if (cfg_start) w_next = S_SYNC;
         default: w_next = S_IDLE;
      endcase
   end

   // Byte counter and running XOR checksum, restarted by each sync byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_byte_cnt <= '0;
         r_csum     <= '0;
      end else if ((r_state == S_SYNC) && w_xfer && (in_data == SYNC_BYTE)) begin
         r_byte_cnt <= '0;
         r_csum     <= '0;
      end else if ((r_state == S_LOAD) && w_xfer) begin
         r_byte_cnt <= r_byte_cnt + 1'b1;
         r_csum     <= r_csum ^ in_data;
      end
   end

   // Shadow assembly; not reset because every byte is rewritten before a commit
   always_ff @(posedge clk) begin
      if ((r_state == S_LOAD) && w_xfer)
         r_shadow[{r_byte_cnt, 3'b000} +: 8] <= in_data;
   end

   // Sticky status: settled by the checksum byte, cleared when a new load starts
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else if (w_restart) begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else if ((r_state == S_CHECK) && w_xfer) begin
         r_done  <= w_commit;
         r_error <= ~w_commit;
      end
   end

   // Atomic commit of every select bus on the edge that accepts a good checksum
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_brb <= '0;
         r_bsb <= '0;
         r_lb  <= '0;
         r_lio <= '0;
         r_rio <= '0;
         r_tio <= '0;
         r_bio <= '0;
      end else if (w_commit) begin
         r_brb <= r_shadow[0 +: BRB_W];
         r_bsb <= r_shadow[BSB_LO +: BSB_W];
         r_lb  <= r_shadow[LB_LO +: LB_W];
         r_lio <= r_shadow[LIO_LO +: IO_W];
         r_rio <= r_shadow[RIO_LO +: IO_W];
         r_tio <= r_shadow[TIO_LO +: IO_W];
         r_bio <= r_shadow[BIO_LO +: IO_W];
      end
   end

   assign in_ready       = w_ready;
   assign cfg_busy       = w_ready;
   assign cfg_done       = r_done;
   assign cfg_error      = r_error;
   assign brbselect      = r_brb;
   assign bsbselect      = r_bsb;
   assign lbselect       = r_lb;
   assign leftioselect   = r_lio;
   assign rightioselect  = r_rio;
   assign topioselect    = r_tio;
   assign bottomioselect = r_bio;
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb_fpga_cfg_loader: directed bench for the configuration loader.
module tb_fpga_cfg_loader;

   localparam int BRB_W   = 900;
   localparam int BSB_W   = 1728;
   localparam int LB_W    = 80;
   localparam int IO_W    = 30;
   localparam int TOTAL_W = 2828;
   localparam int NBYTES  = 354;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SYNC  = 3'd1;
   localparam logic [2:0] ST_LOAD  = 3'd2;
   localparam logic [2:0] ST_CHECK = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [2:0] ST_ERR   = 3'd5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cfg_start = 1'b0;
   logic [7:0]       in_data = 8'h00;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [BRB_W-1:0] brbselect;
   logic [BSB_W-1:0] bsbselect;
   logic [LB_W-1:0]  lbselect;
   logic [IO_W-1:0]  leftioselect;
   logic [IO_W-1:0]  rightioselect;
   logic [IO_W-1:0]  topioselect;
   logic [IO_W-1:0]  bottomioselect;
   logic             cfg_busy;
   logic             cfg_done;
   logic             cfg_error;
   logic [2:0]       dbg_state;

   int checks = 0;
   int errors = 0;

   logic [7:0]         payload [NBYTES];
   logic [TOTAL_W-1:0] exp_buses = '0;
   logic [TOTAL_W-1:0] w_all;

   assign w_all = {bottomioselect, topioselect, rightioselect, leftioselect,
                   lbselect, bsbselect, brbselect};

   fpga_cfg_loader dut (
      .clk            (clk),
      .rst            (rst),
      .cfg_start      (cfg_start),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .brbselect      (brbselect),
      .bsbselect      (bsbselect),
      .lbselect       (lbselect),
      .leftioselect   (leftioselect),
      .rightioselect  (rightioselect),
      .topioselect    (topioselect),
      .bottomioselect (bottomioselect),
      .cfg_busy       (cfg_busy),
      .cfg_done       (cfg_done),
      .cfg_error      (cfg_error),
      .o_dbg_state    (dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_start();
      cfg_start = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      if (in_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL send_byte_timeout in_ready=%b required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom_range(0, 255));
   endtask

   task automatic send_range(input int lo, input int hi, input bit gaps);
      for (int k = lo; k <= hi; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         send_byte(payload[k]);
      end
   endtask

   task automatic set_payload(input logic [7:0] fill);
      for (int k = 0; k < NBYTES; k++) payload[k] = fill;
   endtask

   // Reference: byte k bit j lands on stream bit 8k+j; pad bits are dropped.
   task automatic model_commit();
      logic [8*NBYTES-1:0] s;
      for (int k = 0; k < NBYTES; k++) s[8*k +: 8] = payload[k];
      exp_buses = s[TOTAL_W-1:0];
   endtask

   function automatic int first_diff(input logic [TOTAL_W-1:0] a, input logic [TOTAL_W-1:0] b);
      for (int i = 0; i < TOTAL_W; i++) if (a[i] !== b[i]) return i;
      return -1;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      idle(2);
      checks++;
      if (w_all !== '0) begin errors++;
         $display("FAIL reset_buses first_diff_bit=%0d required all zero", first_diff(w_all, '0)); end
      checks++;
      if ({in_ready, cfg_busy, cfg_done, cfg_error} !== 4'b0000) begin errors++;
         $display("FAIL reset_flags got=%b required 0000", {in_ready, cfg_busy, cfg_done, cfg_error}); end
      checks++;
      if (dbg_state !== ST_IDLE) begin errors++;
         $display("FAIL reset_state got=%0d required %0d", dbg_state, ST_IDLE); end
      in_valid = 1'b1; in_data = 8'hA5; cfg_start = 1'b1;
      idle(2);
      in_valid = 1'b0; idle(1);
      in_valid = 1'b1; idle(1);
      in_valid = 1'b0; cfg_start = 1'b0;
      checks++;
      if (w_all !== '0 || {in_ready, cfg_busy, cfg_done, cfg_error} !== 4'b0000 || dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_hold flags=%b state=%0d required flags 0000 state 0",
                  {in_ready, cfg_busy, cfg_done, cfg_error}, dbg_state);
      end
      rst = 1'b0;
      exp_buses = '0;
      idle(1);
   endtask

   task automatic test_single_bit();
      logic [LB_W-1:0] e_lb;
      e_lb = '0; e_lb[61] = 1'b1; e_lb[62] = 1'b1;
      set_payload(8'h00);
      payload[336] = 8'h06;
      pulse_start();
      checks++;
      if (dbg_state !== ST_SYNC || in_ready !== 1'b1 || cfg_busy !== 1'b1) begin errors++;
         $display("FAIL start_to_sync state=%0d ready=%b busy=%b required 1 1 1", dbg_state, in_ready, cfg_busy); end
      send_byte(8'hA5);
      checks++;
      if (dbg_state !== ST_LOAD) begin errors++;
         $display("FAIL sync_to_load state=%0d required %0d", dbg_state, ST_LOAD); end
      send_range(0, NBYTES-1, 1'b0);
      checks++;
      if (dbg_state !== ST_CHECK || cfg_done !== 1'b0) begin errors++;
         $display("FAIL load_to_check state=%0d done=%b required %0d 0", dbg_state, cfg_done, ST_CHECK); end
      send_byte(8'h06);
      model_commit();
      checks++;
      if (lbselect !== e_lb) begin errors++;
         $display("FAIL single_bit_lb got=%h required %h", lbselect, e_lb); end
      checks++;
      if (w_all !== exp_buses) begin errors++;
         $display("FAIL single_bit_buses first_diff_bit=%0d", first_diff(w_all, exp_buses)); end
      checks++;
      if ({cfg_done, cfg_error, in_ready, cfg_busy} !== 4'b1000 || dbg_state !== ST_DONE) begin errors++;
         $display("FAIL single_bit_status done/err/ready/busy=%b state=%0d required 1000 state %0d",
                  {cfg_done, cfg_error, in_ready, cfg_busy}, dbg_state, ST_DONE); end
   endtask

   task automatic test_all_ones_and_bad_csum();
      logic [LB_W-1:0] e_lb;
      e_lb = '0; e_lb[61] = 1'b1; e_lb[62] = 1'b1;
      set_payload(8'hFF);
      pulse_start();
      checks++;
      if (cfg_done !== 1'b0 || dbg_state !== ST_SYNC) begin errors++;
         $display("FAIL restart_clears_done done=%b state=%0d required 0 %0d", cfg_done, dbg_state, ST_SYNC); end
      send_byte(8'hA5);
      send_range(0, 199, 1'b1);
      checks++;
      if (lbselect !== e_lb || cfg_busy !== 1'b1) begin errors++;
         $display("FAIL hold_during_load lb=%h busy=%b required %h 1", lbselect, cfg_busy, e_lb); end
      send_range(200, NBYTES-1, 1'b0);
      send_byte(8'h00);
      checks++;
      if (w_all !== {TOTAL_W{1'b1}} || cfg_done !== 1'b1) begin errors++;
         $display("FAIL all_ones first_diff_bit=%0d done=%b required all ones, done 1",
                  first_diff(w_all, {TOTAL_W{1'b1}}), cfg_done); end
      exp_buses = {TOTAL_W{1'b1}};
      // same frame, wrong checksum
      pulse_start();
      send_byte(8'hA5);
      send_range(0, NBYTES-1, 1'b0);
      send_byte(8'h01);
      checks++;
      if ({cfg_done, cfg_error} !== 2'b01 || dbg_state !== ST_ERR || in_ready !== 1'b0) begin errors++;
         $display("FAIL bad_csum_status done/err=%b state=%0d ready=%b required 01 %0d 0",
                  {cfg_done, cfg_error}, dbg_state, in_ready, ST_ERR); end
      // zero frame, wrong checksum: buses must not pick up the zeros
      set_payload(8'h00);
      pulse_start();
      checks++;
      if (cfg_error !== 1'b0) begin errors++;
         $display("FAIL restart_clears_error err=%b required 0", cfg_error); end
      send_byte(8'hA5);
      send_range(0, NBYTES-1, 1'b1);
      send_byte(8'h01);
      checks++;
      if (w_all !== exp_buses || cfg_error !== 1'b1) begin errors++;
         $display("FAIL bad_csum_buses_hold first_diff_bit=%0d err=%b required err 1",
                  first_diff(w_all, exp_buses), cfg_error); end
   endtask

   task automatic test_sync_hunt();
      logic [LB_W-1:0] e_lb;
      e_lb = '0; e_lb[61] = 1'b1; e_lb[62] = 1'b1;
      set_payload(8'h00);
      payload[336] = 8'h06;
      pulse_start();
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h5A);
      checks++;
      if (dbg_state !== ST_SYNC) begin errors++;
         $display("FAIL garbage_stays_sync state=%0d required %0d", dbg_state, ST_SYNC); end
      send_byte(8'hA5);
      send_range(0, NBYTES-1, 1'b0);
      send_byte(8'h06);
      model_commit();
      checks++;
      if (lbselect !== e_lb || w_all !== exp_buses || {cfg_done, cfg_error} !== 2'b10) begin errors++;
         $display("FAIL sync_hunt_commit lb=%h done/err=%b first_diff_bit=%0d required lb %h 10",
                  lbselect, {cfg_done, cfg_error}, first_diff(w_all, exp_buses), e_lb); end
   endtask

   task automatic test_rst_midload();
      logic [7:0] c;
      for (int k = 0; k < NBYTES; k++) payload[k] = 8'($urandom_range(0, 255));
      pulse_start();
      send_byte(8'hA5);
      send_range(0, 99, 1'b1);
      rst = 1'b1;
      #3;
      exp_buses = '0;
      checks++;
      if (w_all !== '0 || dbg_state !== ST_IDLE || {in_ready, cfg_busy, cfg_done} !== 3'b000) begin errors++;
         $display("FAIL rst_midload first_diff_bit=%0d state=%0d flags=%b required zeros, state 0",
                  first_diff(w_all, '0), dbg_state, {in_ready, cfg_busy, cfg_done}); end
      @(posedge clk); #1;
      rst = 1'b0;
      idle(1);
      c = 8'h00;
      for (int k = 0; k < NBYTES; k++) begin
         payload[k] = 8'($urandom_range(0, 255));
         c = c ^ payload[k];
      end
      pulse_start();
      send_byte(8'hA5);
      send_range(0, NBYTES-1, 1'b1);
      send_byte(c);
      model_commit();
      checks++;
      if (w_all !== exp_buses || cfg_done !== 1'b1) begin errors++;
         $display("FAIL fresh_frame first_diff_bit=%0d done=%b required done 1",
                  first_diff(w_all, exp_buses), cfg_done); end
   endtask

   task automatic test_pad_bits();
      // Last byte F3: low nibble 3 -> bottomio[27:26]; high nibble is padding.
      set_payload(8'h00);
      payload[353] = 8'hF3;
      pulse_start();
      send_byte(8'hA5);
      send_range(0, NBYTES-1, 1'b0);
      pulse_start();
      checks++;
      if (dbg_state !== ST_CHECK) begin errors++;
         $display("FAIL start_ignored_in_check state=%0d required %0d", dbg_state, ST_CHECK); end
      send_byte(8'hF3);
      model_commit();
      checks++;
      if (bottomioselect !== 30'h0C00_0000 || w_all !== exp_buses || cfg_done !== 1'b1) begin errors++;
         $display("FAIL pad_f3 bottomio=%h done=%b first_diff_bit=%0d required 0c000000 done 1",
                  bottomioselect, cfg_done, first_diff(w_all, exp_buses)); end
      // Last byte FC: bottomio[29:28] set; checksum without the pad nibble (0C) must fail.
      payload[353] = 8'hFC;
      pulse_start();
      send_byte(8'hA5);
      send_range(0, NBYTES-1, 1'b0);
      send_byte(8'h0C);
      checks++;
      if (cfg_error !== 1'b1 || bottomioselect !== 30'h0C00_0000) begin errors++;
         $display("FAIL pad_in_csum err=%b bottomio=%h required 1 0c000000", cfg_error, bottomioselect); end
      pulse_start();
      send_byte(8'hA5);
      send_range(0, NBYTES-1, 1'b1);
      send_byte(8'hFC);
      model_commit();
      checks++;
      if (bottomioselect !== 30'h3000_0000 || w_all !== exp_buses || cfg_done !== 1'b1) begin errors++;
         $display("FAIL pad_fc bottomio=%h done=%b first_diff_bit=%0d required 30000000 done 1",
                  bottomioselect, cfg_done, first_diff(w_all, exp_buses)); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_single_bit();
      test_all_ones_and_bad_csum();
      test_sync_hunt();
      test_rst_midload();
      test_pad_bits();
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
